// File: rtl/dvv_sock_ep_pkg.sv
// rtl/dvv_sock_ep_pkg.sv - shared types and helpers for the dvv socket get endpoint
package dvv_sock_ep_pkg;

  // Get-side handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } get_st_t;

  // Occupancy counter width: one extra bit so a full FIFO (count == DEPTH) is representable
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dvv_sock_fifo.sv
// rtl/dvv_sock_fifo.sv - register-array FIFO with occupancy count and synchronous flush
module dvv_sock_fifo
  import dvv_sock_ep_pkg::*;
#(
  parameter int  DW    = 32,
  parameter int  DEPTH = 4,
  localparam int CW    = cnt_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  // Illegal push into a full FIFO or pop from an empty one leaves state untouched
  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Next-state for storage, pointers and count; flush overrides any push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dvv_sock_get_ep.sv
// rtl/dvv_sock_get_ep.sv - socket reader endpoint: put interface into FIFO, blocking get out
module dvv_sock_get_ep
  import dvv_sock_ep_pkg::*;
#(
  parameter int  DW    = 32,
  parameter int  DEPTH = 4,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          put_vld,
  input  logic [DW-1:0] put_dat,
  output logic          put_rdy,
  input  logic          get_req,
  output logic          get_ack,
  output logic [DW-1:0] get_dat,
  output logic [CW-1:0] count
);

  get_st_t       st_q, st_d;
  logic          get_ack_q, get_ack_d;
  logic [DW-1:0] get_dat_q, get_dat_d;
  logic [DW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Ready comes only from the registered count, so a pop never frees space in the same cycle
  assign put_rdy    = (fifo_count != CW'(DEPTH));
  assign push       = put_vld && put_rdy;
  assign fifo_empty = (fifo_count == '0);

  dvv_sock_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (put_dat),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Get FSM: decide whether to pop this cycle and where to go next
  always_comb begin
    st_d = st_q;
    pop  = 1'b0;
    if (flush) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        IDLE: begin
          if (get_req) begin
            if (!fifo_empty) begin
              pop  = 1'b1;
              st_d = ACK;
            end else begin
              st_d = WAIT;
            end
          end
        end
        WAIT: begin
          // The consumer keeps req high while waiting, so only data availability matters here
          if (!fifo_empty) begin
            pop  = 1'b1;
            st_d = ACK;
          end
        end
        ACK: begin
          if (get_req) begin
            if (!fifo_empty) begin
              pop  = 1'b1;
              st_d = ACK;
            end else begin
              st_d = WAIT;
            end
          end else begin
            st_d = IDLE;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // Output register next-state: a pop is presented as ack plus data one cycle later
  always_comb begin
    get_ack_d = pop;
    get_dat_d = pop ? fifo_dout : get_dat_q;
  end

  // FSM and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      get_ack_q <= 1'b0;
      get_dat_q <= '0;
    end else begin
      st_q      <= st_d;
      get_ack_q <= get_ack_d;
      get_dat_q <= get_dat_d;
    end
  end

  assign get_ack = get_ack_q;
  assign get_dat = get_dat_q;
  assign count   = fifo_count;

endmodule

// File: tb/tb_dvv_sock_get_ep.sv
// tb/tb_dvv_sock_get_ep.sv - directed self-checking bench for dvv_sock_get_ep
module tb_dvv_sock_get_ep;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        put_vld;
  logic [31:0] put_dat;
  logic        put_rdy;
  logic        get_req;
  logic        get_ack;
  logic [31:0] get_dat;
  logic [2:0]  count;

  int n_cmp;
  int n_bad;

  dvv_sock_get_ep #(
    .DW    (32),
    .DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .put_vld (put_vld),
    .put_dat (put_dat),
    .put_rdy (put_rdy),
    .get_req (get_req),
    .get_ack (get_ack),
    .get_dat (get_dat),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (put_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_put_rdy: got %b want 1", put_rdy); end
    n_cmp++; if (get_ack !== 1'b0) begin n_bad++; $display("FAIL reset_get_ack: got %b want 0", get_ack); end
    n_cmp++; if (get_dat !== 32'h0) begin n_bad++; $display("FAIL reset_get_dat: got %h want 0", get_dat); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    #10;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (get_ack !== 1'b0 || count !== 3'd0 || put_rdy !== 1'b1 || get_dat !== 32'h0) begin
        n_bad++;
        $display("FAIL idle_stable: got ack=%b cnt=%0d rdy=%b dat=%h want ack=0 cnt=0 rdy=1 dat=0",
                 get_ack, count, put_rdy, get_dat);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_dat [5];
    logic [2:0]  exp_cnt [5];
    exp_dat = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    exp_cnt = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    put_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put_dat = exp_dat[i];
      step();
    end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", count); end
    n_cmp++; if (put_rdy !== 1'b0) begin n_bad++; $display("FAIL fill_put_rdy: got %b want 0", put_rdy); end
    put_dat = 32'h55;
    step();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_hold_count: got %0d want 4", count); end
    n_cmp++; if (get_ack !== 1'b0) begin n_bad++; $display("FAIL full_no_ack: got %b want 0", get_ack); end
    get_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (get_ack !== 1'b1 || get_dat !== exp_dat[i] || count !== exp_cnt[i]) begin
        n_bad++;
        $display("FAIL drain_%0d: got ack=%b dat=%h cnt=%0d want ack=1 dat=%h cnt=%0d",
                 i, get_ack, get_dat, count, exp_dat[i], exp_cnt[i]);
      end
      if (i == 0) begin
        n_cmp++; if (put_rdy !== 1'b1) begin n_bad++; $display("FAIL rdy_after_pop: got %b want 1", put_rdy); end
      end
      if (i == 1) put_vld = 1'b0;
      if (i == 4) get_req = 1'b0;
    end
    step();
    n_cmp++;
    if (get_ack !== 1'b0 || get_dat !== 32'h55) begin
      n_bad++;
      $display("FAIL drain_end: got ack=%b dat=%h want ack=0 dat=00000055", get_ack, get_dat);
    end
  endtask

  task automatic test_blocking_get();
    get_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (get_ack !== 1'b0) begin n_bad++; $display("FAIL wait_no_ack_%0d: got %b want 0", i, get_ack); end
    end
    put_vld = 1'b1;
    put_dat = 32'hA5;
    step();
    n_cmp++;
    if (get_ack !== 1'b0 || count !== 3'd1) begin
      n_bad++;
      $display("FAIL wait_n1: got ack=%b cnt=%0d want ack=0 cnt=1", get_ack, count);
    end
    put_vld = 1'b0;
    step();
    n_cmp++;
    if (get_ack !== 1'b1 || get_dat !== 32'hA5 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL wait_n2: got ack=%b dat=%h cnt=%0d want ack=1 dat=000000a5 cnt=0", get_ack, get_dat, count);
    end
    get_req = 1'b0;
    step();
    n_cmp++; if (get_ack !== 1'b0) begin n_bad++; $display("FAIL wait_end: got %b want 0", get_ack); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_c;
    put_vld = 1'b1;
    put_dat = 32'h100;
    step();
    put_dat = 32'h101;
    step();
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL b2b_prefill: got %0d want 2", count); end
    get_req = 1'b1;
    put_dat = 32'h102;
    for (int k = 0; k < 14; k++) begin
      step();
      exp_c = (k < 12) ? 3'd2 : 3'(13 - k);
      n_cmp++;
      if (get_ack !== 1'b1 || get_dat !== 32'(32'h100 + k) || count !== exp_c) begin
        n_bad++;
        $display("FAIL b2b_%0d: got ack=%b dat=%h cnt=%0d want ack=1 dat=%h cnt=%0d",
                 k, get_ack, get_dat, count, 32'h100 + k, exp_c);
      end
      put_dat = 32'h103 + k;
      if (k == 11) put_vld = 1'b0;
      if (k == 13) get_req = 1'b0;
    end
    step();
    n_cmp++; if (get_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b want 0", get_ack); end
  endtask

  task automatic test_flush();
    put_vld = 1'b1;
    put_dat = 32'hB1; step();
    put_dat = 32'hB2; step();
    put_dat = 32'hB3; step();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL flush_prefill: got %0d want 3", count); end
    flush   = 1'b1;
    get_req = 1'b1;
    put_dat = 32'hEE;
    step();
    n_cmp++;
    if (count !== 3'd0 || get_ack !== 1'b0 || get_dat !== 32'h10D || put_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_edge: got cnt=%0d ack=%b dat=%h rdy=%b want cnt=0 ack=0 dat=0000010d rdy=1",
               count, get_ack, get_dat, put_rdy);
    end
    flush   = 1'b0;
    put_vld = 1'b0;
    step();
    n_cmp++;
    if (get_ack !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL flush_dropped: got ack=%b cnt=%0d want ack=0 cnt=0", get_ack, count);
    end
    put_vld = 1'b1;
    put_dat = 32'hC1;
    step();
    put_vld = 1'b0;
    n_cmp++; if (get_ack !== 1'b0) begin n_bad++; $display("FAIL flush_post_n1: got %b want 0", get_ack); end
    step();
    n_cmp++;
    if (get_ack !== 1'b1 || get_dat !== 32'hC1) begin
      n_bad++;
      $display("FAIL flush_post_get: got ack=%b dat=%h want ack=1 dat=000000c1", get_ack, get_dat);
    end
    get_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_get();
    put_vld = 1'b1;
    put_dat = 32'hD1; step();
    put_dat = 32'hD2; step();
    put_dat = 32'hD3; step();
    put_dat = 32'hD4; step();
    put_vld = 1'b0;
    get_req = 1'b1;
    step();
    step();
    n_cmp++;
    if (get_ack !== 1'b1 || get_dat !== 32'hD2 || count !== 3'd2) begin
      n_bad++;
      $display("FAIL rmid_pre: got ack=%b dat=%h cnt=%0d want ack=1 dat=000000d2 cnt=2", get_ack, get_dat, count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (get_ack !== 1'b0 || count !== 3'd0 || put_rdy !== 1'b1 || get_dat !== 32'h0) begin
      n_bad++;
      $display("FAIL rmid_async: got ack=%b cnt=%0d rdy=%b dat=%h want ack=0 cnt=0 rdy=1 dat=0",
               get_ack, count, put_rdy, get_dat);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (get_ack !== 1'b0 || count !== 3'd0) begin
        n_bad++;
        $display("FAIL rmid_wait_%0d: got ack=%b cnt=%0d want ack=0 cnt=0", i, get_ack, count);
      end
    end
    put_vld = 1'b1;
    put_dat = 32'hE7;
    step();
    put_vld = 1'b0;
    n_cmp++; if (get_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_n1: got %b want 0", get_ack); end
    step();
    n_cmp++;
    if (get_ack !== 1'b1 || get_dat !== 32'hE7) begin
      n_bad++;
      $display("FAIL rmid_get: got ack=%b dat=%h want ack=1 dat=000000e7", get_ack, get_dat);
    end
    get_req = 1'b0;
    step();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    put_vld = 1'b0;
    put_dat = '0;
    get_req = 1'b0;
    test_reset();
    test_fill_drain();
    test_blocking_get();
    test_back_to_back();
    test_flush();
    test_reset_mid_get();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
